me_result_collector: RTL and testbench
======================================

# me_result_collector

Downstream stage of `me_iddmm_top`. It captures the stream of K-bit result words that the modular-exponentiation core emits on `me_result`/`me_valid` and assembles them into one K*N-bit result buffer. The buffer is exposed to the SoC-side RSA register block through a 32-bit random-access read port. Collection is armed by the same `me_start` pulse that launches the core, so the collector and the core always track the same operation.

## Interface
Parameters:
- `K`, 128: width of one result word from the core.
- `N`, 16: words per result; the result width is K*N (2048 at defaults).
- `W`, 32: read-port data width; K*N must be a multiple of W, and K must be a multiple of W.

Ports:
- `clk`  in  1  single clock; every register is updated on its rising edge.
- `rst`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `me_start`  in  1  one-cycle arm pulse, driven in parallel with the core's `me_start`.
- `me_result`  in  K  result word from the core.
- `me_valid`  in  1  `me_result` is valid this cycle. No backpressure; the collector must accept every word.
- `rd_en`  in  1  read request.
- `rd_addr`  in  $clog2(K*N/W)  W-bit chunk index; chunk j is bits [W*j+W-1 : W*j] of the assembled result.
- `rd_data`  out  W  registered read data.
- `rd_valid`  out  1  `rd_data` is valid; pulses one cycle after `rd_en`.
- `busy`  out  1  high while collecting.
- `done`  out  1  level; all N words have been captured.
- `overflow`  out  1  sticky; a `me_valid` arrived while in DONE.
- `word_cnt`  out  $clog2(N+1)  number of words captured in the current operation.

## Operation
- The state machine has three states: IDLE, COLLECT and DONE. Reset enters IDLE.
- IDLE:
  - `me_valid` is ignored. Nothing is stored and no flag changes.
  - `me_start` moves the block to COLLECT and sets `word_cnt`=0, `done`=0, `overflow`=0.
- COLLECT:
  - Each `me_valid` writes `me_result` into buffer slot `word_cnt` (LSW-first) and increments `word_cnt`.
  - The write that makes `word_cnt`=N moves the block to DONE and sets `done`=1.
- DONE:
  - The buffer is frozen.
  - Any `me_valid` is discarded and sets `overflow`=1.
  - `me_start` re-arms the block exactly as it does from IDLE.
- `me_start` during COLLECT restarts collection: `word_cnt`=0, and the buffer contents are not cleared.
- If `me_start` and `me_valid` are high in the same cycle, `me_start` wins. The word is discarded and `word_cnt` becomes 0.
- Reads are legal in any state and return the current buffer contents. Reads never stall or alter collection.
- A read and a buffer write in the same cycle to the same chunk return the pre-write data.
- Buffer slot s occupies bits [K*s+K-1 : K*s] of the result.
- `busy` = (state == COLLECT). `done` = (state == DONE).

## Timing
- Reset values: state=IDLE, buffer all-zero, `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0, `overflow`=0, `word_cnt`=0.
- `rst` mid-operation aborts collection on the next edge and clears all of the above, buffer included.
- `me_start` sampled at edge t: `busy`=1 and `word_cnt`=0 from t+1. The first capturable `me_valid` is at edge t+1.
- Capture latency: `me_valid` at edge t updates the buffer and `word_cnt` at t+1.
- The Nth word at edge t gives `done`=1 and `busy`=0 from t+1.
- Back-to-back `me_valid` every cycle is supported, with no gaps required.
- Read latency: `rd_en` at edge t gives `rd_data` and `rd_valid`=1 at t+1. `rd_valid` drops at t+2 if `rd_en` was low at t+1.
- `rd_data` holds its last value when `rd_valid`=0.
- `rd_addr` values outside range cannot occur at the default parameters, because the range is exactly a power of two.

## Configuration
- The macro `ME_COLLECT_MSW_FIRST_EN` selects the word order.
- Without the macro (default), the first word received is stored in slot 0, i.e. the least-significant K bits. This matches the order in which operands are fed to the core.
- With the macro defined, the first word received is stored in slot N-1 and subsequent words go to descending slots.
  - `word_cnt` still counts up from 0 to N.
  - DONE, overflow and read-port behaviour are unchanged.

## Test plan
- Reset, then read chunks 0..63 -> `rd_data`=0 for every chunk, `done`=0, `busy`=0, `overflow`=0.
- `me_start`, then 16 consecutive `me_valid` with `me_result` = {4{32'(i)}} for i=0..15 (default build):
  - `done` rises exactly one cycle after the 16th word.
  - Reading chunk j returns j>>2.
  - With `ME_COLLECT_MSW_FIRST_EN` defined, chunk j returns 15-(j>>2).
- After DONE, send a 17th `me_valid` with value all-ones -> `overflow`=1, and every chunk is unchanged.
- In the next `me_start`, `overflow` clears.
- `me_start` after 5 words, then 16 words of value 0xA5-pattern -> `word_cnt` reaches 16 and every chunk reads 0xA5A5A5A5.
- `me_start` and `me_valid` in the same cycle -> that word is not stored and `word_cnt`=0 in the next cycle.
- `rst` asserted after 8 of 16 words -> all outputs return to reset values on the next edge, and subsequent `me_valid` words are ignored while in IDLE.

Source files
------------

// File: rtl/me_result_collector_if.sv
// Bus bundle for me_result_collector: core result stream in, SoC read port out.
// slave modport = collector side, master modport = driver (core + SoC register block).
interface me_result_collector_if #(
  parameter int K = 128,
  parameter int N = 16,
  parameter int W = 32
);
  localparam int AW = $clog2(K*N/W);
  localparam int CW = $clog2(N+1);

  // Handshake rules:
  // - me_valid qualifies me_result in the cycle it is high. There is no ready
  //   signal; the collector takes every word.
  // - rd_en in cycle t returns rd_data with rd_valid=1 in cycle t+1. A read never
  //   stalls, and rd_data holds its value while rd_valid is low.
  logic          me_start;
  logic          me_valid;
  logic [K-1:0]  me_result;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [CW-1:0] word_cnt;
  logic [1:0]    state_dbg;

  modport master (
    output me_start, me_valid, me_result, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, overflow, word_cnt, state_dbg
  );

  modport slave (
    input  me_start, me_valid, me_result, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, overflow, word_cnt, state_dbg
  );
endinterface

// File: rtl/me_result_collector.sv
// me_result_collector: assembles N K-bit result words from the modexp core into a
// K*N-bit buffer and serves it as W-bit chunks through a registered read port.
// Optional macro ME_COLLECT_MSW_FIRST_EN: store the first received word in slot
// N-1 (descending slots) instead of slot 0.
module me_result_collector #(
  parameter int K = 128,
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst,
  me_result_collector_if.slave bus
);
  localparam int CW = $clog2(N+1);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [K*N-1:0]  buf_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic [SW-1:0]   slot;
  logic            wr_en;
  logic            last_word;

  // A word is only stored while collecting, and a simultaneous me_start wins.
  assign wr_en     = (state_q == ST_COLLECT) && bus.me_valid && !bus.me_start;
  assign last_word = (cnt_q == CW'(N-1));

`ifdef ME_COLLECT_MSW_FIRST_EN
  assign slot = SW'(N-1) - cnt_q[SW-1:0];
`else
  assign slot = cnt_q[SW-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: me_start (re)arms from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.me_start) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (bus.me_start)                   state_d = ST_COLLECT;
        else if (bus.me_valid && last_word) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.me_start) state_d = ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state and counters.
  always_comb begin
    bus.busy      = (state_q == ST_COLLECT);
    bus.done      = (state_q == ST_DONE);
    bus.state_dbg = state_q;
    bus.word_cnt  = cnt_q;
    bus.overflow  = ovf_q;
  end

  // Word counter and sticky overflow flag; arming clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.me_start) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) cnt_q <= cnt_q + CW'(1);
      if ((state_q == ST_DONE) && bus.me_valid) ovf_q <= 1'b1;
    end
  end

  // Result buffer: one K-bit slot written per accepted word; a restart leaves it intact.
  always_ff @(posedge clk) begin
    if (rst)        buf_q <= '0;
    else if (wr_en) buf_q[K*int'(slot) +: K] <= bus.me_result;
  end

  // Registered read port; reads the pre-write buffer when a write lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= buf_q[W*int'(bus.rd_addr) +: W];
    end
  end

endmodule

// File: tb/tb_me_result_collector.sv
// Testbench for me_result_collector: directed test-plan sequences plus random
// traffic, checked against a word-array reference model and a read scoreboard.
module tb_me_result_collector;
  localparam int K  = 128;
  localparam int N  = 16;
  localparam int W  = 32;
  localparam int AW = $clog2(K*N/W);
  localparam int NCHUNK = K*N/W;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  me_result_collector_if #(.K(K), .N(N), .W(W)) bus ();

  me_result_collector #(.K(K), .N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Result held as an array of N words; phase 0=idle, 1=collecting, 2=complete.
  logic [K-1:0] m_words [N];
  int           m_phase;
  int           m_cnt;
  bit           m_ovf;
  logic [W-1:0] m_last_rd;
  logic [W-1:0] exp_q [$];

  function automatic int model_slot(input int n);
`ifdef ME_COLLECT_MSW_FIRST_EN
    return N - 1 - n;
`else
    return n;
`endif
  endfunction

  function automatic logic [W-1:0] model_chunk(input int a);
    int bit_pos;
    bit_pos = a * W;
    return m_words[bit_pos / K][(bit_pos % K) +: W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_words[i] = '0;
    m_phase   = 0;
    m_cnt     = 0;
    m_ovf     = 1'b0;
    m_last_rd = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit s, input bit v, input logic [K-1:0] r);
    if (s) begin
      m_phase = 1;
      m_cnt   = 0;
      m_ovf   = 1'b0;
    end else if (v && m_phase == 1) begin
      m_words[model_slot(m_cnt)] = r;
      m_cnt++;
      if (m_cnt == N) m_phase = 2;
    end else if (v && m_phase == 2) begin
      m_ovf = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, let the edge sample them, then compare all outputs.
  task automatic cycle(input bit s, input bit v, input logic [K-1:0] r,
                       input bit re, input logic [AW-1:0] a);
    bus.me_start  = s;
    bus.me_valid  = v;
    bus.me_result = r;
    bus.rd_en     = re;
    bus.rd_addr   = a;
    if (re && !rst) exp_q.push_back(model_chunk(int'(a)));
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(s, v, r);
    #1;
    if (!rst && re) begin
      if (exp_q.size() > 0) m_last_rd = exp_q.pop_front();
      else check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end
    check("busy",     32'(bus.busy),     32'(m_phase == 1));
    check("done",     32'(bus.done),     32'(m_phase == 2));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
    check("rd_valid", 32'(bus.rd_valid), 32'(re && !rst));
    check("rd_data",  bus.rd_data,       m_last_rd);
    bus.me_start = 1'b0;
    bus.me_valid = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic read_chunk(input int a, output logic [W-1:0] d);
    cycle(1'b0, 1'b0, '0, 1'b1, AW'(a));
    d = bus.rd_data;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] counting_chunk(input int j);
`ifdef ME_COLLECT_MSW_FIRST_EN
    return W'(15 - (j >> 2));
`else
    return W'(j >> 2);
`endif
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    logic [K-1:0] pat;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.me_start  = 1'b0;
    bus.me_valid  = 1'b0;
    bus.me_result = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    model_reset();

    // Reset state: every chunk reads zero.
    apply_reset();
    for (int j = 0; j < NCHUNK; j++) begin
      read_chunk(j, d);
      check("reset_chunk", d, 32'd0);
    end

    // Full collection of counting words.
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, {4{32'(i)}}, 1'b0, '0);
    check("done_after_16", 32'(bus.done), 32'd1);
    for (int j = 0; j < NCHUNK; j++) begin
      read_chunk(j, d);
      check("count_chunk", d, counting_chunk(j));
    end

    // Extra word after DONE: overflow, buffer frozen.
    cycle(1'b0, 1'b1, {K{1'b1}}, 1'b0, '0);
    check("overflow_set", 32'(bus.overflow), 32'd1);
    for (int j = 0; j < NCHUNK; j++) begin
      read_chunk(j, d);
      check("frozen_chunk", d, counting_chunk(j));
    end

    // Re-arm clears overflow; restart after 5 words, then 16 A5 words.
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    check("overflow_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    pat = {4{32'hA5A5A5A5}};
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, pat, 1'b0, '0);
    check("a5_word_cnt", 32'(bus.word_cnt), 32'd16);
    for (int j = 0; j < NCHUNK; j++) begin
      read_chunk(j, d);
      check("a5_chunk", d, 32'hA5A5A5A5);
    end

    // me_start and me_valid together: word dropped, count restarts.
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, {4{32'h11111111}}, 1'b0, '0);
    cycle(1'b1, 1'b1, {4{32'h22222222}}, 1'b0, '0);
    check("start_wins_cnt", 32'(bus.word_cnt), 32'd0);

    // Reset after 8 words, then valids while idle are ignored.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, {4{32'h5A5A0000 | 32'(i)}}, 1'b0, '0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt",  32'(bus.word_cnt), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, {4{32'hDEADBEEF}}, 1'b0, '0);
    for (int j = 0; j < NCHUNK; j += 7) begin
      read_chunk(j, d);
      check("idle_chunk", d, 32'd0);
    end

    // Random traffic: concurrent reads and captures, occasional restarts and resets.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0,
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, NCHUNK - 1)));
    end
    rst = 1'b0;
    idle();
    for (int j = 0; j < NCHUNK; j++) read_chunk(j, d);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
